// File: rtl/dmem_pkg.sv
// Shared encodings and defaults for the data-memory bridge.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h1001_0000;

  typedef enum logic {IDLE, BUSY} state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter  int unsigned DEPTH_WORDS = 2048,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    // Read port only updates on a read accept, so the word stays stable for the delay stages.
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_bridge.sv
// CPU data-port bridge: valid/ready request, single-pulse response, sub-word
// access with extension, configurable read latency and a sticky fault register.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $fatal(1, "dmem_bridge: READ_LAT must be 1..4");
  end
  if (DEPTH_WORDS < 16 || DEPTH_WORDS > 65536 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $fatal(1, "dmem_bridge: DEPTH_WORDS must be a power of two in 16..65536");
  end

  state_e      state, state_nxt;
  logic [2:0]  cnt;
  logic        we_q, sgn_q, flt_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] rdata_hold;

  logic        accept;
  logic [31:0] offset, idx_full;
  logic        bad_size, bad_align, bad_range, flt_now;
  logic [2:0]  lat_load;
  logic [3:0]  be, ram_we;
  logic [31:0] wlanes;
  logic        ram_re;
  logic [31:0] ram_rdata, rd_final, ext;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign accept   = req_valid && req_ready;
  assign offset   = req_addr - ADDR_BASE;
  assign idx_full = {2'b00, offset[31:2]};
  assign lat_load = req_we ? 3'd1 : 3'(READ_LAT);

  always_comb begin
    bad_size  = (req_size == SIZE_ILL);
    bad_align = ((req_size == SIZE_HALF) && req_addr[0]) ||
                ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    bad_range = (req_addr < ADDR_BASE) || (idx_full >= 32'(DEPTH_WORDS));
    flt_now   = bad_size || bad_align || bad_range;
  end

  always_comb begin
    be     = '0;
    wlanes = '0;
    case (req_size)
      SIZE_BYTE: begin
        be     = 4'b0001 << req_addr[1:0];
        wlanes = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        be     = req_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        be     = 4'b1111;
        wlanes = req_wdata;
      end
      default: ;
    endcase
  end

  // Reset gates the RAM strobes so an accept coinciding with reset has no effect.
  assign ram_we = (accept && req_we && !flt_now && !reset) ? be : '0;
  assign ram_re = accept && !req_we && !reset;

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx_full[AW-1:0]),
    .wdata (wlanes),
    .rdata (ram_rdata)
  );

  if (READ_LAT > 1) begin : g_dly
    logic [31:0] dly [READ_LAT-1];
    always_ff @(posedge clk) begin
      if (reset) begin
        dly <= '{default: '0};
      end else begin
        dly[0] <= ram_rdata;
        for (int unsigned k = 1; k < READ_LAT - 1; k++) dly[k] <= dly[k-1];
      end
    end
    assign rd_final = dly[READ_LAT-2];
  end else begin : g_nodly
    assign rd_final = ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == 3'd1) begin
          rsp_valid = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      flt_q      <= 1'b0;
      size_q     <= '0;
      lane_q     <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
      rdata_hold <= '0;
    end else begin
      if (accept) begin
        cnt    <= lat_load;
        we_q   <= req_we;
        sgn_q  <= req_signed;
        size_q <= req_size;
        lane_q <= req_addr[1:0];
        flt_q  <= flt_now;
        if (flt_now) begin
          fault <= 1'b1;
          if (!fault) fault_addr <= req_addr;
        end
      end else if (state == BUSY) begin
        cnt <= cnt - 3'd1;
      end
      if (rsp_valid) rdata_hold <= rsp_rdata;
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    sel_byte = rd_final[7:0];
      2'd1:    sel_byte = rd_final[15:8];
      2'd2:    sel_byte = rd_final[23:16];
      default: sel_byte = rd_final[31:24];
    endcase
    sel_half = lane_q[1] ? rd_final[31:16] : rd_final[15:0];
    case (size_q)
      SIZE_BYTE: ext = {{24{sgn_q & sel_byte[7]}}, sel_byte};
      SIZE_HALF: ext = {{16{sgn_q & sel_half[15]}}, sel_half};
      default:   ext = rd_final;
    endcase
  end

  always_comb begin
    rsp_rdata = rdata_hold;
    if (rsp_valid) rsp_rdata = (we_q || flt_q) ? '0 : ext;
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: DUT A (READ_LAT=2, 2048 words), DUT B (READ_LAT=3, 16 words).
module tb_dmem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_req_valid, a_req_ready, a_req_we, a_req_signed, a_rsp_valid, a_fault;
  logic [1:0]  a_req_size;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_fault_addr;
  logic        b_reset, b_req_valid, b_req_ready, b_req_we, b_req_signed, b_rsp_valid, b_fault;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_fault_addr;

  int checks = 0;
  int failures = 0;

  dmem_bridge #(.ADDR_BASE(32'h1001_0000), .DEPTH_WORDS(2048), .READ_LAT(2)) dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_size(a_req_size), .req_signed(a_req_signed),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rsp_rdata), .fault(a_fault), .fault_addr(a_fault_addr)
  );

  dmem_bridge #(.ADDR_BASE(32'h1001_0000), .DEPTH_WORDS(16), .READ_LAT(3)) dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_size(b_req_size), .req_signed(b_req_signed),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .fault(b_fault), .fault_addr(b_fault_addr)
  );

  // Issues one request on DUT A (sel=0) or B (sel=1) and observes 8 cycles after the accept edge.
  // lat = first cycle with rsp_valid (-1 if none), npulse = rsp_valid count, rdy[c-1] = req_ready in T+c.
  task automatic xact(input bit sel, input logic we, input logic [1:0] size, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      output int lat, output int npulse, output logic [31:0] data,
                      output logic [7:0] rdy);
    logic v, r;
    logic [31:0] d;
    @(negedge clk);
    if (sel) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_size = size; b_req_signed = sg;
      b_req_addr = addr; b_req_wdata = wd;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_size = size; a_req_signed = sg;
      a_req_addr = addr; a_req_wdata = wd;
    end
    @(posedge clk);
    #1;
    if (hold == 0) begin a_req_valid = 1'b0; b_req_valid = 1'b0; end
    lat = -1; npulse = 0; data = '0; rdy = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      v = sel ? b_rsp_valid : a_rsp_valid;
      r = sel ? b_req_ready : a_req_ready;
      d = sel ? b_rsp_rdata : a_rsp_rdata;
      rdy[c-1] = r;
      if (v) begin
        npulse++;
        if (lat < 0) begin lat = c; data = d; end
      end
      if (c == hold) begin a_req_valid = 1'b0; b_req_valid = 1'b0; end
    end
  endtask

  task automatic test_reset;
    a_reset = 1'b1; b_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_reset = 1'b0; b_reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_fault !== 1'b0 || a_fault_addr !== 32'h0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d: ready=%b rsp_valid=%b fault=%b fault_addr=%h, want 1 0 0 00000000",
                 c, a_req_ready, a_rsp_valid, a_fault, a_fault_addr);
      end
      checks++;
      if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_fault !== 1'b0 || b_fault_addr !== 32'h0) begin
        failures++;
        $display("FAIL reset_state_b cyc=%0d: ready=%b rsp_valid=%b fault=%b fault_addr=%h, want 1 0 0 00000000",
                 c, b_req_ready, b_rsp_valid, b_fault, b_fault_addr);
      end
    end
  endtask

  task automatic test_word_latency;
    int lat, np; logic [31:0] d; logic [7:0] rdy;
    xact(1'b0, 1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 0, lat, np, d, rdy);
    checks++;
    if (lat != 1 || np != 1) begin
      failures++;
      $display("FAIL write_latency: lat=%0d pulses=%0d, want 1 1", lat, np);
    end
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || np != 1 || d !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL word_read: lat=%0d pulses=%0d data=%h, want 2 1 deadbeef", lat, np, d);
    end
    checks++;
    if (rdy[2:0] !== 3'b100) begin
      failures++;
      $display("FAIL read_ready_busy: ready(T+1..T+3)=%b, want 001 (low,low,high)", {rdy[0], rdy[1], rdy[2]});
    end
  endtask

  task automatic test_subword;
    int lat, np; logic [31:0] d; logic [7:0] rdy;
    xact(1'b0, 1'b1, 2'd0, 1'b0, 32'h1001_0007, 32'h0000_0080, 0, lat, np, d, rdy);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL byte_write_lat: lat=%0d, want 1", lat); end
    xact(1'b0, 1'b0, 2'd0, 1'b1, 32'h1001_0007, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || d !== 32'hFFFF_FF80) begin
      failures++; $display("FAIL byte_signed: lat=%0d data=%h, want 2 ffffff80", lat, d);
    end
    xact(1'b0, 1'b0, 2'd0, 1'b0, 32'h1001_0007, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || d !== 32'h0000_0080) begin
      failures++; $display("FAIL byte_unsigned: lat=%0d data=%h, want 2 00000080", lat, d);
    end
    xact(1'b0, 1'b0, 2'd1, 1'b1, 32'h1001_0006, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || d !== 32'hFFFF_80AD) begin
      failures++; $display("FAIL half_signed: lat=%0d data=%h, want 2 ffff80ad", lat, d);
    end
    xact(1'b0, 1'b0, 2'd0, 1'b0, 32'h1001_0005, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || d !== 32'h0000_00BE) begin
      failures++; $display("FAIL byte_lane1: lat=%0d data=%h, want 2 000000be", lat, d);
    end
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || d !== 32'h80AD_BEEF) begin
      failures++; $display("FAIL word_after_byte: lat=%0d data=%h, want 2 80adbeef", lat, d);
    end
  endtask

  task automatic test_fault;
    int lat, np; logic [31:0] d; logic [7:0] rdy;
    checks++;
    if (a_fault !== 1'b0) begin failures++; $display("FAIL fault_clear_before: fault=%b, want 0", a_fault); end
    xact(1'b0, 1'b0, 2'd1, 1'b0, 32'h1001_0001, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || np != 1 || d !== 32'h0) begin
      failures++; $display("FAIL misaligned_rsp: lat=%0d pulses=%0d data=%h, want 2 1 00000000", lat, np, d);
    end
    checks++;
    if (a_fault !== 1'b1 || a_fault_addr !== 32'h1001_0001) begin
      failures++; $display("FAIL misaligned_fault: fault=%b addr=%h, want 1 10010001", a_fault, a_fault_addr);
    end
    xact(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000_FFFC, 32'hCAFE_F00D, 0, lat, np, d, rdy);
    checks++;
    if (lat != 1 || a_fault !== 1'b1 || a_fault_addr !== 32'h1001_0001) begin
      failures++;
      $display("FAIL first_fault_wins: lat=%0d fault=%b addr=%h, want 1 1 10010001", lat, a_fault, a_fault_addr);
    end
    xact(1'b0, 1'b0, 2'd3, 1'b0, 32'h1001_0004, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || d !== 32'h0) begin
      failures++; $display("FAIL illegal_size: lat=%0d data=%h, want 2 00000000", lat, d);
    end
  endtask

  task automatic test_range;
    int lat, np; logic [31:0] d; logic [7:0] rdy;
    xact(1'b0, 1'b1, 2'd2, 1'b0, 32'h1001_0000, 32'hA5A5_0000, 0, lat, np, d, rdy);
    xact(1'b0, 1'b1, 2'd2, 1'b0, 32'h1001_2000, 32'h1234_5678, 0, lat, np, d, rdy);
    checks++;
    if (lat != 1 || a_fault !== 1'b1) begin
      failures++; $display("FAIL range_write: lat=%0d fault=%b, want 1 1", lat, a_fault);
    end
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || d !== 32'hA5A5_0000) begin
      failures++; $display("FAIL no_alias: lat=%0d data=%h, want 2 a5a50000", lat, d);
    end
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h1001_1FFC, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 2 || a_fault_addr !== 32'h1001_0001) begin
      failures++; $display("FAIL last_word_ok: lat=%0d fault_addr=%h, want 2 10010001", lat, a_fault_addr);
    end
  endtask

  task automatic test_lat3_and_reset;
    int lat, np; logic [31:0] d; logic [7:0] rdy;
    xact(1'b1, 1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'h0BAD_F00D, 0, lat, np, d, rdy);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL b_write_lat: lat=%0d, want 1", lat); end
    xact(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0, 3, lat, np, d, rdy);
    checks++;
    if (lat != 3 || np != 1 || d !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL b_read_held_valid: lat=%0d pulses=%0d data=%h, want 3 1 0badf00d", lat, np, d);
    end
    // Read accepted at T, reset high through cycle T+1.
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = 2'd2; b_req_addr = 32'h1001_0008;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0;
    b_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (b_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_t1: rsp_valid=%b, want 0", b_rsp_valid); end
    @(posedge clk);
    #1;
    b_reset = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
        failures++;
        $display("FAIL rst_mid_T+%0d: rsp_valid=%b ready=%b, want 0 1", c, b_rsp_valid, b_req_ready);
      end
    end
    // Write presented while reset is high must not land.
    @(negedge clk);
    b_reset = 1'b1;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 2'd2; b_req_addr = 32'h1001_0008;
    b_req_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0;
    b_reset = 1'b0;
    xact(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 3 || d !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL write_in_reset: lat=%0d data=%h, want 3 0badf00d", lat, d);
    end
    xact(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001_0040, 32'h0, 0, lat, np, d, rdy);
    checks++;
    if (lat != 3 || d !== 32'h0 || b_fault !== 1'b1 || b_fault_addr !== 32'h1001_0040) begin
      failures++;
      $display("FAIL b_range: lat=%0d data=%h fault=%b addr=%h, want 3 00000000 1 10010040",
               lat, d, b_fault, b_fault_addr);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = '0; a_req_signed = 1'b0;
    a_req_addr = '0; a_req_wdata = '0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = '0; b_req_signed = 1'b0;
    b_req_addr = '0; b_req_wdata = '0;
    test_reset();
    test_word_latency();
    test_subword();
    test_fault();
    test_range();
    test_lat3_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
Parametrised data-memory bridge between the CPU data port and an internal word-organised RAM.
- Replaces the fixed "(addr - 0x1001_0000)/4" word-only, zero-latency data path with a valid/ready request channel and a response channel.
- Adds byte/halfword/word access with little-endian lane selection, signed/unsigned read extension and configurable read latency.
- Detects misaligned, illegal-size and out-of-range accesses and records them in a sticky fault register.
- Sits in the computer top between the CPU core and the data memory.

Parameters:
- ADDR_BASE, 32'h1001_0000, byte address of RAM word 0.
- DEPTH_WORDS, 2048, RAM depth in 32-bit words; power of two, 16..65536.
- READ_LAT, 1, cycles from read accept to read response; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend byte/half reads.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended read data; 0 for writes and faulted requests.
- fault  out  1  sticky fault flag.
- fault_addr  out  32  req_addr of the first faulting request.

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, fault=0, fault_addr=0, state=IDLE. RAM contents are not cleared.
- FSM has two states, IDLE and BUSY. req_ready = (state==IDLE).
- Accept occurs when req_valid && req_ready at cycle T. Latch we, size, signed, addr, wdata, and load a latency counter with L.
  - L = 1 for writes; L = READ_LAT for reads.
  - Faulted requests use the same L as their type.
- In BUSY, rsp_valid=1 exactly in cycle T+L, and the FSM returns to IDLE at T+L+1. Minimum accept interval is L+1 cycles.
- req_valid and request fields are ignored while in BUSY. There is only ever one outstanding request.
- Index computation: idx = (req_addr - ADDR_BASE) >> 2.
- Fault conditions (evaluated at accept):
  - req_size==3.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr < ADDR_BASE.
  - idx >= DEPTH_WORDS. No wrap-around or aliasing.
- Faulted request handling:
  - No RAM write.
  - Response still issued, with rsp_rdata=0.
  - fault is set at T+1.
  - fault_addr is loaded only if fault was 0; the first fault wins.
  - Only reset clears fault.
- Writes, byte-enables committed at the clock edge ending cycle T:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes {addr[1],1'b0} and +1 get wdata[15:0], low byte at the lower address.
  - word: all four lanes.
- Reads use registered RAM output plus (READ_LAT-1) delay stages, then lane select by latched addr[1:0]:
  - byte: sign- or zero-extend bit 7.
  - half: extend bit 15.
  - word: passed through.
- rsp_rdata holds its value outside rsp_valid cycles; it is only meaningful when rsp_valid=1.
- Reset mid-operation: the in-flight request is abandoned, no rsp_valid is issued, and any pending read data is discarded. A write accepted in the same cycle that reset is high is not performed.
- Elaboration must fail on READ_LAT outside 1..4 or a DEPTH_WORDS that is not a power of two.

Decomposition:
- dmem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL constants.
  - FSM state enum {IDLE, BUSY}.
  - Default ADDR_BASE.
- Sub-module dmem_ram(DEPTH_WORDS): single-port synchronous RAM, 4-bit byte-enable write, registered 32-bit read.
- Lane muxing, extension, fault logic, latency counter and FSM stay in dmem_bridge.

Test Plan:
1. Hold reset 2 cycles, release, keep req_valid=0 -> req_ready=1, rsp_valid=0, fault=0, fault_addr=0 on every cycle.
2. READ_LAT=2: word write 0xDEADBEEF @0x1001_0004 at T -> rsp_valid at T+1. Then word read @0x1001_0004 accepted at T' -> rsp_valid only at T'+2, rsp_rdata=0xDEADBEEF, req_ready low T'+1..T'+2.
3. After test 2, byte write 0x80 @0x1001_0007:
   - signed byte read -> 0xFFFFFF80.
   - unsigned byte read -> 0x00000080.
   - signed half read @0x1001_0006 -> 0xFFFF80AD.
   - word read @0x1001_0004 -> 0x80ADBEEF.
4. Half read @0x1001_0001 -> rsp_valid with rdata 0, fault=1, fault_addr=0x1001_0001. Then word write @0x1000_FFFC -> fault_addr stays 0x1001_0001.
5. Word write 0x12345678 to ADDR_BASE+4*DEPTH_WORDS -> fault set, no write. Read @0x1001_0000 returns its previous value (no aliasing).
6. READ_LAT=3: accept a read at T, assert reset at T+1 -> no rsp_valid at T+3, req_ready=1 from T+2. req_valid pulses held during BUSY in other runs produce no extra responses.
